// File: rtl/elastic_pkg.sv
// Shared definitions for the elastic stream stages: width helpers and the
// valid/ready handshake bundle used on both sides of each stage.
package elastic_pkg;

  // Handshake pair carried alongside every elastic data path.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Ceiling log2 that returns 0 for n <= 1 instead of relying on tool behaviour.
  function automatic int clog2_safe(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Sum width that holds nbeats full-scale words without wrapping.
  function automatic int sum_width(input int dw, input int nb);
    int r;
    r = dw + clog2_safe(nb);
    return (r < dw) ? dw : r;
  endfunction

  // Counter width able to represent 0..nb.
  function automatic int cnt_width(input int nb);
    int r;
    r = clog2_safe(nb + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/elastic_out_reg.sv
// Single-entry output holding register with valid/ready semantics. A load
// always wins over a consume, so a close arriving in the same cycle as a
// transfer replaces the word with no bubble.
module elastic_out_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         in_ready_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Upstream may push whenever the slot is empty or is being drained this cycle.
  assign in_ready_o = ~valid_q | ready_i;

  // Next-state: load, consume or hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register; reset clears both the pending flag and the word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_accum.sv
// Groups consecutive input words into sums of up to NBEATS beats (closing
// early on t0_last) and presents one widened sum per group downstream.
module elastic_accum
  import elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NBEATS = 4,
  localparam int SUM_W = sum_width(DATA_W, NBEATS),
  localparam int CNT_W = cnt_width(NBEATS)
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic [DATA_W-1:0] t0_data,
  input  logic              t0_valid,
  input  logic              t0_last,
  output logic              t0_ready,
  output logic [SUM_W-1:0]  i0_data,
  output logic [CNT_W-1:0]  i0_count,
  output logic              i0_valid,
  input  logic              i0_ready
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             acc_in;
  logic             close;
  logic             out_valid;
  logic [CNT_W+SUM_W-1:0] out_word;
  hs_t              out_hs;

  assign acc_in   = t0_valid & t0_ready;
  assign close    = t0_last | (cnt_q == CNT_W'(NBEATS - 1));
  assign sum_next = acc_q + SUM_W'(t0_data);
  assign cnt_next = cnt_q + CNT_W'(1);

  // Running sum/count: advance on non-closing beats, restart after a close.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (acc_in) begin
      if (close) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_next;
      end
    end
  end

  // Accumulator state; reset discards any partial group.
  always_ff @(posedge clk) begin
    if (rstf) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_hs.ready = i0_ready;
  assign out_hs.valid = out_valid;

  elastic_out_reg #(
    .W(CNT_W + SUM_W)
  ) u_out (
    .clk_i      (clk),
    .rst_i      (rstf),
    .load_i     (acc_in & close),
    .data_i     ({cnt_next, sum_next}),
    .ready_i    (out_hs.ready),
    .valid_o    (out_valid),
    .data_o     (out_word),
    .in_ready_o (t0_ready)
  );

  assign i0_valid = out_hs.valid;
  assign i0_data  = out_word[SUM_W-1:0];
  assign i0_count = out_word[CNT_W+SUM_W-1:SUM_W];

endmodule

// File: tb/tb_elastic_accum.sv
module tb_elastic_accum;

  localparam int DATA_W = 32;
  localparam int NBEATS = 4;
  localparam int SUM_W  = 34;
  localparam int CNT_W  = 3;
  localparam logic [63:0] MASK = 64'h3_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rstf = 1'b1;
  logic [DATA_W-1:0] t0_data = '0;
  logic              t0_valid = 1'b0;
  logic              t0_last = 1'b0;
  logic              t0_ready;
  logic [SUM_W-1:0]  i0_data;
  logic [CNT_W-1:0]  i0_count;
  logic              i0_valid;
  logic              i0_ready = 1'b1;

  typedef struct {
    logic [63:0] sum;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_sum = '0;
  int          m_cnt = 0;
  bit          rst_chk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  elastic_accum #(
    .DATA_W(DATA_W),
    .NBEATS(NBEATS)
  ) dut (
    .clk      (clk),
    .rstf     (rstf),
    .t0_data  (t0_data),
    .t0_valid (t0_valid),
    .t0_last  (t0_last),
    .t0_ready (t0_ready),
    .i0_data  (i0_data),
    .i0_count (i0_count),
    .i0_valid (i0_valid),
    .i0_ready (i0_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the reference model updates when a beat is accepted.
  task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                     input logic r, input logic rs);
    @(negedge clk);
    #1;
    t0_valid = v;
    t0_data  = d;
    t0_last  = l;
    i0_ready = r;
    rstf     = rs;
    #2;
    if (rs) begin
      exp_q.delete();
      m_sum   = '0;
      m_cnt   = 0;
      rst_chk = 1'b1;
    end else if (v && t0_ready) begin
      m_sum = m_sum + {32'd0, d};
      m_cnt = m_cnt + 1;
      if (l || m_cnt == NBEATS) begin
        exp_q.push_back('{m_sum & MASK, m_cnt});
        m_sum = '0;
        m_cnt = 0;
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_chk) begin
        chk("reset_valid", {63'd0, i0_valid}, 64'd0);
        chk("reset_data", {30'd0, i0_data}, 64'd0);
        chk("reset_count", {61'd0, i0_count}, 64'd0);
        chk("reset_t0_ready", {63'd0, t0_ready}, 64'd1);
        rst_chk = 1'b0;
      end else begin
        chk("valid", {63'd0, i0_valid}, {63'd0, (exp_q.size() != 0)});
        chk("t0_ready", {63'd0, t0_ready}, {63'd0, (exp_q.size() == 0) || i0_ready});
        if (i0_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("sum", {30'd0, i0_data}, e.sum);
          chk("count", {61'd0, i0_count}, 64'(e.cnt));
          if (i0_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    // Basic group 1,2,3,4
    for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Early close 5, 7(last)
    cyc(1, 5, 0, 1, 0);
    cyc(1, 7, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Back-pressure: group closes while downstream stalls
    for (int i = 0; i < 4; i++) cyc(1, 32'(10 + i), 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'h55, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Width: four full-scale words
    for (int i = 0; i < 4; i++) cyc(1, 32'hFFFF_FFFF, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Reset mid-group, then 1,1,1,1
    cyc(1, 9, 0, 1, 0);
    cyc(1, 9, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Reset while a sum is pending
    for (int i = 0; i < 4; i++) cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    // Streaming 0..15
    for (int i = 0; i < 16; i++) cyc(1, 32'(i), 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Last with valid low is ignored
    cyc(1, 2, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(1, 3, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
    end
    // Drain and confirm nothing is left outstanding
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
